// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module      : stopwatch_pkg
// Description : State encoding, tick default and max-count digits for the
//               stopwatch controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

  localparam int C_TICK_DIV_DEFAULT = 10_000_000;

  localparam logic [2:0] C_ST_IDLE       = 3'd0;
  localparam logic [2:0] C_ST_RUN_UP     = 3'd1;
  localparam logic [2:0] C_ST_PAUSE_UP   = 3'd2;
  localparam logic [2:0] C_ST_RUN_DOWN   = 3'd3;
  localparam logic [2:0] C_ST_PAUSE_DOWN = 3'd4;
  localparam logic [2:0] C_ST_DONE       = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE       = C_ST_IDLE,
    ST_RUN_UP     = C_ST_RUN_UP,
    ST_PAUSE_UP   = C_ST_PAUSE_UP,
    ST_RUN_DOWN   = C_ST_RUN_DOWN,
    ST_PAUSE_DOWN = C_ST_PAUSE_DOWN,
    ST_DONE       = C_ST_DONE
  } state_t;

  // Highest displayable count is 9:59.9
  localparam logic [3:0] C_MAX_MINUTE    = 4'd9;
  localparam logic [3:0] C_MAX_SEC_TENS  = 4'd5;
  localparam logic [3:0] C_MAX_SEC_UNITS = 4'd9;
  localparam logic [3:0] C_MAX_TENTH     = 4'd9;

  typedef struct packed {
    logic [3:0] minute;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
    logic [3:0] tenth;
  } digits_t;

  function automatic logic digits_at_max(input digits_t d);
    return (d.minute    == C_MAX_MINUTE)    &&
           (d.sec_tens  == C_MAX_SEC_TENS)  &&
           (d.sec_units == C_MAX_SEC_UNITS) &&
           (d.tenth     == C_MAX_TENTH);
  endfunction

  function automatic logic digits_are_zero(input digits_t d);
    return (d == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stopwatch_if.sv
// ============================================================================
// Module      : stopwatch_if
// Description : Command, digit and control signals between the stopwatch
//               controller and its datapath/button front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_if;

  logic       start_stop;
  logic       clear;
  logic       load;
  logic       mode_down;
  logic [3:0] minute;
  logic [3:0] sec_tens;
  logic [3:0] sec_units;
  logic [3:0] tenth;

  logic       count_up_enable;
  logic       count_down_enable;
  logic       tick;
  logic       load_preset;
  logic       clear_count;
  logic [2:0] state;

  modport master (
    output start_stop, clear, load, mode_down,
    output minute, sec_tens, sec_units, tenth,
    input  count_up_enable, count_down_enable, tick,
    input  load_preset, clear_count, state
  );

  modport slave (
    input  start_stop, clear, load, mode_down,
    input  minute, sec_tens, sec_units, tenth,
    output count_up_enable, count_down_enable, tick,
    output load_preset, clear_count, state
  );

endinterface

`default_nettype wire

// File: rtl/tenth_tick_gen.sv
// ============================================================================
// Module      : tenth_tick_gen
// Description : Divides the system clock down to one tick per TICK_DIV cycles
//               while run is high; restarts from zero on every run entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tenth_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = C_TICK_DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int                 C_CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TICK_DIV - 1);

  logic [C_CNT_W-1:0] r_cnt;
  logic               r_running;
  logic               r_tick;

  // run is the controller's next-cycle enable, so the tick register lines up
  // with the registered enables and never fires on the cycle they drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_running <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_running <= run;
      if (!run || !r_running) begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end else if (r_cnt == C_CNT_LAST) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_cnt  <= r_cnt + C_CNT_W'(1);
        r_tick <= 1'b0;
      end
    end
  end

  assign tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run/pause/done control FSM for a BCD stopwatch with up and
//               down counting, preset load and clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = C_TICK_DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  stopwatch_if.slave sw
);

  state_t  r_state;
  state_t  w_next_state;
  logic    r_count_up_enable;
  logic    r_count_down_enable;
  logic    r_load_preset;
  logic    r_clear_count;
  logic    w_tick;
  logic    w_load_ok;
  logic    w_run_next;
  digits_t w_digits;

  assign w_digits  = {sw.minute, sw.sec_tens, sw.sec_units, sw.tenth};
  assign w_load_ok = (r_state == ST_IDLE)       || (r_state == ST_PAUSE_UP) ||
                     (r_state == ST_PAUSE_DOWN) || (r_state == ST_DONE);

  // clear > accepted load > start_stop; a load ignored in RUN lets start_stop act
  always_comb begin
    w_next_state = r_state;
    if (sw.clear) begin
      w_next_state = ST_IDLE;
    end else if (sw.load && w_load_ok) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sw.start_stop) begin
            if (!sw.mode_down)
              w_next_state = ST_RUN_UP;
            else if (!digits_are_zero(w_digits))
              w_next_state = ST_RUN_DOWN;
          end
        end
        ST_RUN_UP: begin
          if (w_tick && digits_at_max(w_digits))
            w_next_state = ST_DONE;
          else if (sw.start_stop)
            w_next_state = ST_PAUSE_UP;
        end
        ST_PAUSE_UP: begin
          if (sw.start_stop)
            w_next_state = ST_RUN_UP;
        end
        ST_RUN_DOWN: begin
          if (digits_are_zero(w_digits))
            w_next_state = ST_IDLE;
          else if (sw.start_stop)
            w_next_state = ST_PAUSE_DOWN;
        end
        ST_PAUSE_DOWN: begin
          if (sw.start_stop)
            w_next_state = ST_RUN_DOWN;
        end
        ST_DONE: begin
          w_next_state = ST_DONE;
        end
        default: begin
          w_next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign w_run_next = (w_next_state == ST_RUN_UP) || (w_next_state == ST_RUN_DOWN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state             <= ST_IDLE;
      r_count_up_enable   <= 1'b0;
      r_count_down_enable <= 1'b0;
      r_load_preset       <= 1'b0;
      r_clear_count       <= 1'b0;
    end else begin
      r_state             <= w_next_state;
      r_count_up_enable   <= (w_next_state == ST_RUN_UP);
      r_count_down_enable <= (w_next_state == ST_RUN_DOWN);
      r_load_preset       <= !sw.clear && sw.load && w_load_ok;
      r_clear_count       <= sw.clear;
    end
  end

  tenth_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .run     (w_run_next),
    .tick    (w_tick)
  );

  assign sw.count_up_enable   = r_count_up_enable;
  assign sw.count_down_enable = r_count_down_enable;
  assign sw.tick              = w_tick;
  assign sw.load_preset       = r_load_preset;
  assign sw.clear_count       = r_clear_count;
  assign sw.state             = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Directed scoreboard bench for stopwatch_ctrl with TICK_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int TICK_DIV = 4;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  stopwatch_if sw_if ();

  stopwatch_ctrl #(
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .sw      (sw_if)
  );

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;

  // Expected bundle: {state[2:0], up_en, down_en, tick, load_preset, clear_count}
  task automatic expect_out(input string tag, input logic [2:0] st, input logic cue,
                            input logic cde, input logic tk, input logic lp, input logic cc);
    sb_item_t it;
    it.tag = tag;
    it.exp = {st, cue, cde, tk, lp, cc};
    sb_q.push_back(it);
  endtask

  task automatic check_out();
    sb_item_t   it;
    logic [7:0] obs;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed nothing expected");
      return;
    end
    it  = sb_q.pop_front();
    obs = {sw_if.state, sw_if.count_up_enable, sw_if.count_down_enable,
           sw_if.tick, sw_if.load_preset, sw_if.clear_count};
    assert (obs === it.exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b (state,up,down,tick,load,clear)",
             it.tag, obs, it.exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st, input logic cue,
                     input logic cde, input logic tk, input logic lp, input logic cc);
    expect_out(tag, st, cue, cde, tk, lp, cc);
    @(posedge clock);
    @(negedge clock);
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.load       = 1'b0;
    check_out();
  endtask

  task automatic set_digits(input logic [3:0] m, input logic [3:0] st,
                            input logic [3:0] su, input logic [3:0] t);
    sw_if.minute    = m;
    sw_if.sec_tens  = st;
    sw_if.sec_units = su;
    sw_if.tenth     = t;
  endtask

  initial begin
    reset_n          = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.clear      = 1'b0;
    sw_if.load       = 1'b0;
    sw_if.mode_down  = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (2) @(negedge clock);
    expect_out("reset_state", C_ST_IDLE, 0, 0, 0, 0, 0);
    check_out();
    reset_n = 1'b1;

    // Count up: enable one cycle after start, ticks every 4 cycles
    sw_if.start_stop = 1'b1;
    cyc("start_up", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      cyc("tick_up", C_ST_RUN_UP, 1, 0, logic'(i % 4 == 0), 0, 0);

    // Reaching 9:59.9 on a tick ends the run; DONE ignores start_stop
    cyc("up_no_max", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    set_digits(4'd9, 4'd5, 4'd9, 4'd9);
    cyc("max_wait1", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    cyc("max_wait2", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    cyc("tick_at_max", C_ST_RUN_UP, 1, 0, 1, 0, 0);
    cyc("done_at_max", C_ST_DONE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) sw_if.start_stop = 1'b1;
      cyc("done_hold", C_ST_DONE, 0, 0, 0, 0, 0);
    end
    sw_if.clear = 1'b1;
    cyc("clear_done", C_ST_IDLE, 0, 0, 0, 0, 1);
    cyc("idle_after_clear", C_ST_IDLE, 0, 0, 0, 0, 0);

    // Count down: zero digits refuse to start; 0:00.1 runs to zero and stops
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    sw_if.mode_down  = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc("down_zero_stays_idle", C_ST_IDLE, 0, 0, 0, 0, 0);
    set_digits(4'd0, 4'd0, 4'd0, 4'd1);
    sw_if.start_stop = 1'b1;
    cyc("start_down", C_ST_RUN_DOWN, 0, 1, 0, 0, 0);
    sw_if.mode_down = 1'b0;
    for (int i = 1; i <= 3; i++)
      cyc("down_wait", C_ST_RUN_DOWN, 0, 1, 0, 0, 0);
    cyc("tick_down", C_ST_RUN_DOWN, 0, 1, 1, 0, 0);
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    cyc("down_reach_zero", C_ST_IDLE, 0, 0, 0, 0, 0);

    // Load ignored while running, accepted in pause
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    sw_if.mode_down  = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc("start_down2", C_ST_RUN_DOWN, 0, 1, 0, 0, 0);
    sw_if.load = 1'b1;
    cyc("load_in_run_ignored", C_ST_RUN_DOWN, 0, 1, 0, 0, 0);
    sw_if.start_stop = 1'b1;
    cyc("pause_down", C_ST_PAUSE_DOWN, 0, 0, 0, 0, 0);
    cyc("pause_down_hold", C_ST_PAUSE_DOWN, 0, 0, 0, 0, 0);
    sw_if.load = 1'b1;
    cyc("load_in_pause", C_ST_IDLE, 0, 0, 0, 1, 0);
    cyc("load_pulse_ends", C_ST_IDLE, 0, 0, 0, 0, 0);

    // Pause discards the partial tick; clear and load beat start_stop
    sw_if.mode_down  = 1'b0;
    sw_if.start_stop = 1'b1;
    cyc("start_up2", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    cyc("partial1", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    cyc("partial2", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    sw_if.start_stop = 1'b1;
    cyc("pause_up", C_ST_PAUSE_UP, 0, 0, 0, 0, 0);
    cyc("pause_up_hold", C_ST_PAUSE_UP, 0, 0, 0, 0, 0);
    sw_if.start_stop = 1'b1;
    cyc("resume_up", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      cyc("tick_after_resume", C_ST_RUN_UP, 1, 0, logic'(i == 4), 0, 0);
    sw_if.start_stop = 1'b1;
    cyc("pause_up2", C_ST_PAUSE_UP, 0, 0, 0, 0, 0);
    sw_if.clear      = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc("clear_beats_start", C_ST_IDLE, 0, 0, 0, 0, 1);
    cyc("clear_pulse_ends", C_ST_IDLE, 0, 0, 0, 0, 0);
    sw_if.start_stop = 1'b1;
    cyc("start_up3", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    sw_if.start_stop = 1'b1;
    cyc("pause_up3", C_ST_PAUSE_UP, 0, 0, 0, 0, 0);
    sw_if.load       = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc("load_beats_start", C_ST_IDLE, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-run, then a clean restart
    sw_if.start_stop = 1'b1;
    cyc("start_up4", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    cyc("div1", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    cyc("div2", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    expect_out("reset_async", C_ST_IDLE, 0, 0, 0, 0, 0);
    check_out();
    @(negedge clock);
    expect_out("reset_held", C_ST_IDLE, 0, 0, 0, 0, 0);
    check_out();
    reset_n          = 1'b1;
    sw_if.start_stop = 1'b1;
    cyc("restart_up", C_ST_RUN_UP, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++)
      cyc("tick_after_restart", C_ST_RUN_UP, 1, 0, logic'(i == 4), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, clock cycles per 0.1 s tick at 100 MHz.
REQ-002 clock  in  1  100 MHz system clock; all logic on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 start_stop  in  1  debounced single-cycle pulse; toggles run/pause.
REQ-005 clear  in  1  debounced single-cycle pulse; zeroes count and returns to IDLE.
REQ-006 load  in  1  debounced single-cycle pulse; requests preset load.
REQ-007 mode_down  in  1  level; 0 = count up, 1 = count down; sampled only on start from IDLE.
REQ-008 minute, sec_tens, sec_units, tenth  in  4 each  current BCD count digits from the counter datapath.
REQ-009 count_up_enable  out  1  high while in RUN_UP.
REQ-010 count_down_enable  out  1  high while in RUN_DOWN.
REQ-011 tick  out  1  single-cycle pulse every TICK_DIV cycles while running; the counter advances one tenth per tick.
REQ-012 load_preset  out  1  single-cycle pulse instructing the datapath to load the preset.
REQ-013 clear_count  out  1  single-cycle pulse instructing the datapath to zero all digits.
REQ-014 state  out  3  current FSM state encoding, for display and debug.

Function
REQ-015 States: IDLE, RUN_UP, PAUSE_UP, RUN_DOWN, PAUSE_DOWN, DONE.
REQ-016 IDLE + start_stop: go to RUN_UP if mode_down=0; go to RUN_DOWN if mode_down=1 and the digits are nonzero; otherwise stay in IDLE.
REQ-017 RUN_x + start_stop: go to PAUSE_x. PAUSE_x + start_stop: go to RUN_x. mode_down is ignored outside IDLE.
REQ-018 RUN_UP with digits 9:59.9 coincident with tick: go to DONE; no further ticks are issued.
REQ-019 RUN_DOWN with all digits 0: go to IDLE on the next edge; enables drop.
REQ-020 DONE: ignores start_stop; leaves only on clear or load.
REQ-021 load in IDLE, PAUSE_x or DONE: pulse load_preset for one cycle, next state IDLE; load in RUN_x is ignored.
REQ-022 clear in any state: pulse clear_count for one cycle, next state IDLE.
REQ-023 Priority when pulses coincide: clear > load > start_stop.
REQ-024 Outputs are registered: a pulse at edge N produces the state and enable change visible after edge N+1 (one-cycle latency).
REQ-025 Tick divider: ceil(log2(TICK_DIV)) bits; zeroed on entering any RUN state; counts while in RUN; asserts tick and wraps to 0 at TICK_DIV-1; holds at 0 outside RUN.
REQ-026 First tick occurs exactly TICK_DIV cycles after the run enable rises; a pause discards the partial tick.
REQ-027 Enables are mutually exclusive; tick is never asserted while both enables are low.

Reset
REQ-028 reset_n low: state=IDLE, divider=0, and all outputs 0, asynchronously; reset mid-run aborts with no pulses issued.
REQ-029 Reset release is synchronous to clock; the first transition is possible on the first edge after release.

Structure
REQ-030 Shared package stopwatch_pkg holds the state encoding constants, the TICK_DIV default, and the max-count digit constants (9, 5, 9, 9).
REQ-031 The tick divider is sub-module tenth_tick_gen (ports: clock, reset_n, run, tick); the FSM remains in stopwatch_ctrl.

Verification
REQ-032 Bench uses TICK_DIV=4. Reset; start_stop with mode_down=0 -> count_up_enable=1 one cycle later; tick pulses at cycles 4, 8, 12.
REQ-033 Digits at 9:59.9 in RUN_UP at a tick -> state=DONE; tick stays 0 for 20 cycles; start_stop ignored.
REQ-034 Digits at 0:00.1 in RUN_DOWN -> after tick the digits become 0 -> state=IDLE; count_down_enable=0.
REQ-035 Same-cycle clear+start_stop in PAUSE_UP -> clear_count is one 1-cycle pulse; state=IDLE; no enable asserted.
REQ-036 load during RUN_DOWN -> no load_preset; load in PAUSE_DOWN -> a 1-cycle load_preset and IDLE.
REQ-037 reset_n low mid-RUN_UP with divider=2 -> outputs 0 immediately; after release, restart gives its first tick 4 cycles after the enable.
